// File: rtl/muldiv_pkg.sv
// Purpose : shared op codes, FSM encoding and parameter legality check for the mul/div unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: OP_* op-code localparams, state_t FSM encoding, steps_legal() configuration check.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DIV   = 2'd2,
        ST_FIXUP = 2'd3
    } state_t;

    // Width must be even and >= 8; steps per cycle 1, 2 or 4 and must divide the width.
    function automatic bit steps_legal(input int width, input int steps);
        return ((steps == 1) || (steps == 2) || (steps == 4)) &&
               (width % steps == 0) && (width % 2 == 0) && (width >= 8);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Purpose : shared 2*WIDTH shift register doing radix-2 shift-add multiply or restoring divide.
// Latency : WIDTH/STEPS_PER_CYCLE cycles after start; done is high during the last iteration cycle.
// Backpr. : none; start is only asserted by the owner when the core is idle.
// Ports   : clock, reset_n, start/div_mode/load_a/load_b (load), acc (result), done (last step).
//           Multiply: acc = load_a * load_b. Divide: acc = {remainder, quotient} of load_a / load_b.
module muldiv_iter_core #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   load_a,
    input  logic [WIDTH-1:0]   load_b,
    output logic [2*WIDTH-1:0] acc,
    output logic               done
);

    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]      cnt;
    logic               running;
    logic               mode;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    assign done = running && (cnt == CW'(N - 1));

    // Multiply: low half holds the multiplier and shifts out LSB-first while the
    // partial product grows in the high half; the carry rides in sum[WIDTH].
    // Divide: high half is the partial remainder, low half shifts the dividend
    // out and quotient bits in. The remainder stays below the divisor, so the
    // shifted remainder always fits in WIDTH+1 bits.
    always_comb begin
        acc_next = acc;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            if (mode) begin
                rem_sh = acc_next[2*WIDTH-1:WIDTH-1];
                diff   = rem_sh - {1'b0, opnd};
                if (!diff[WIDTH]) begin
                    acc_next = {diff[WIDTH-1:0], acc_next[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next = {rem_sh[WIDTH-1:0], acc_next[WIDTH-2:0], 1'b0};
                end
            end else begin
                sum      = {1'b0, acc_next[2*WIDTH-1:WIDTH]} +
                           (acc_next[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
                acc_next = {sum, acc_next[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            opnd    <= '0;
            mode    <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            acc     <= {{WIDTH{1'b0}}, load_a};
            opnd    <= load_b;
            mode    <= div_mode;
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_exec_unit.sv
// Purpose : multi-cycle MULT/DIV/MFxx/MTxx execution unit with architectural HI/LO.
// Latency : mul/div 1 + WIDTH/STEPS_PER_CYCLE + 1 cycles to HI/LO; MF* result one cycle after accept.
// Backpr. : in_ready low while an op iterates or an MF* result waits on out_ready; result held until taken.
// Ports   : clock, reset_n; request channel in_valid/in_ready/op/src_a/src_b;
//           result channel out_valid/out_ready/result; status busy, div_by_zero (1-cycle pulse).
// Option  : define MULDIV_EXEC_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 8-11); otherwise no-ops.
module muldiv_exec_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             div_by_zero
);

    if (!steps_legal(WIDTH, STEPS_PER_CYCLE)) begin : g_bad_cfg
        $error("muldiv_exec_unit: illegal WIDTH/STEPS_PER_CYCLE combination");
    end

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               res_neg;   // product / quotient must be negated in FIXUP
    logic               rem_neg;   // remainder takes the dividend's sign
    logic               fix_div;

    logic               accept;
    logic               is_mul;
    logic               is_div;
    logic               mul_signed;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               core_start;
    logic               core_done;
    logic [2*WIDTH-1:0] core_acc;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

`ifdef MULDIV_EXEC_MADD_EN
    logic               acc_en;
    logic               acc_sub;
`endif

    assign in_ready = (state == ST_IDLE) && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_mul     = (op == OP_MULT) || (op == OP_MULTU);
        mul_signed = (op == OP_MULT);
`ifdef MULDIV_EXEC_MADD_EN
        is_mul     = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                     (op == OP_MSUB) || (op == OP_MSUBU);
        mul_signed = mul_signed || (op == OP_MADD) || (op == OP_MSUB);
`endif
        is_div     = (op == OP_DIV) || (op == OP_DIVU);
        op_signed  = mul_signed || (op == OP_DIV);
        a_neg      = op_signed && src_a[WIDTH-1];
        b_neg      = op_signed && src_b[WIDTH-1];
        // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
        a_mag      = a_neg ? -src_a : src_a;
        b_mag      = b_neg ? -src_b : src_b;
        core_start = accept && (is_mul || (is_div && (src_b != '0)));
    end

    muldiv_iter_core #(
        .WIDTH           (WIDTH),
        .STEPS_PER_CYCLE (STEPS_PER_CYCLE)
    ) u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (core_start),
        .div_mode (is_div),
        .load_a   (a_mag),
        .load_b   (b_mag),
        .acc      (core_acc),
        .done     (core_done)
    );

    // Sign fix-up. The signed-overflow divide falls out naturally: both signs
    // negative leave the 2^(WIDTH-1) quotient unnegated with a zero remainder.
    always_comb begin
        prod = res_neg ? -core_acc : core_acc;
        quo  = res_neg ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
        rem  = rem_neg ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EXEC_MADD_EN
        if (acc_en) begin
            mul_res = acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
        end else begin
            mul_res = prod;
        end
`else
        mul_res = prod;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            hi          <= '0;
            lo          <= '0;
            result      <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            fix_div     <= 1'b0;
`ifdef MULDIV_EXEC_MADD_EN
            acc_en      <= 1'b0;
            acc_sub     <= 1'b0;
`endif
        end else begin
            div_by_zero <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state   <= ST_MUL;
                                busy    <= 1'b1;
                                fix_div <= 1'b0;
                                res_neg <= a_neg ^ b_neg;
`ifdef MULDIV_EXEC_MADD_EN
                                acc_en  <= 1'b0;
`endif
                            end
`ifdef MULDIV_EXEC_MADD_EN
                            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                state   <= ST_MUL;
                                busy    <= 1'b1;
                                fix_div <= 1'b0;
                                res_neg <= a_neg ^ b_neg;
                                acc_en  <= 1'b1;
                                acc_sub <= (op == OP_MSUB) || (op == OP_MSUBU);
                            end
`else
                            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                // accumulate ops are accepted and dropped in this build
                            end
`endif
                            OP_DIV, OP_DIVU: begin
                                if (src_b == '0) begin
                                    lo          <= '1;
                                    hi          <= src_a;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    state   <= ST_DIV;
                                    busy    <= 1'b1;
                                    fix_div <= 1'b1;
                                    res_neg <= a_neg ^ b_neg;
                                    rem_neg <= a_neg;
                                end
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            OP_MFHI: begin
                                result    <= hi;
                                out_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                result    <= lo;
                                out_valid <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (core_done) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (fix_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        {hi, lo} <= mul_res;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
`timescale 1ns/1ps
module tb_muldiv_exec_unit;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_exec_unit #(
        .WIDTH           (32),
        .STEPS_PER_CYCLE (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one request at a negedge, hold it across the accepting posedge; returns #1 after it.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout op=%0d in_ready=%b required 1", o, in_ready);
        end
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] o, output logic [31:0] v);
        issue(o, 32'd0, 32'd0);
        v = result;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle_timeout busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({result, out_valid, busy, div_by_zero, in_ready} !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs result=%h ov=%b busy=%b dbz=%b ir=%b required 0/0/0/0/1",
                     result, out_valid, busy, div_by_zero, in_ready);
        end
        reset_n = 1'b1;
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h required 00000000", v); end
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h required 00000000", v); end
    endtask

    task automatic test_mult();
        logic [31:0] v;
        int bcnt = 0;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mult_in_ready got=%b required 0", in_ready); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy) bcnt++;
            else break;
        end
        n_cmp++;
        if (bcnt != 33) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d required 33", bcnt); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h required ffffffff", v); end
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got=%h required ffffffeb", v); end

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got=%h required fffffffe", v); end
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got=%h required 00000001", v); end

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle();
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi got=%h required 40000000", v); end
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_lo got=%h required 00000000", v); end
    endtask

    task automatic test_div();
        logic [31:0] a_tab [4] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] b_tab [4] = '{32'hFFFF_FFFE, 32'd2, 32'h10, 32'hFFFF_FFFF};
        logic [3:0]  o_tab [4] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] q_tab [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0FFF_FFFF, 32'h8000_0000};
        logic [31:0] r_tab [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_0000};
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            issue(o_tab[i], a_tab[i], b_tab[i]);
            wait_idle();
            read_reg(OP_MFLO, v);
            n_cmp++;
            if (v !== q_tab[i]) begin
                n_fail++;
                $display("FAIL div_lo[%0d] got=%h required %h", i, v, q_tab[i]);
            end
            read_reg(OP_MFHI, v);
            n_cmp++;
            if (v !== r_tab[i]) begin
                n_fail++;
                $display("FAIL div_hi[%0d] got=%h required %h", i, v, r_tab[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] v;
        int dcnt = 0;
        int bcnt = 0;
        issue(OP_DIVU, 32'h8000_0000, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (div_by_zero) dcnt++;
            if (busy) bcnt++;
        end
        n_cmp++;
        if (dcnt != 1) begin n_fail++; $display("FAIL dbz_pulse_cycles got=%0d required 1", dcnt); end
        n_cmp++;
        if (bcnt != 0) begin n_fail++; $display("FAIL dbz_busy_cycles got=%0d required 0", bcnt); end
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo got=%h required ffffffff", v); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'h8000_0000) begin n_fail++; $display("FAIL dbz_hi got=%h required 80000000", v); end
    endtask

    task automatic test_mt_mf_backpressure();
        logic [31:0] v;
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        out_ready = 1'b0;
        issue(OP_MFHI, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({out_valid, result, in_ready} !== {1'b1, 32'h1234_5678, 1'b0}) begin
                n_fail++;
                $display("FAIL mf_hold[%0d] ov=%b result=%h ir=%b required 1/12345678/0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mf_release ov=%b ir=%b required 0/1", out_valid, in_ready);
        end
        // Back-to-back register moves with no idle cycle between them.
        issue(OP_MTLO, 32'hA5A5_0F0F, 32'd0);
        issue(OP_MTHI, 32'h0BAD_F00D, 32'd0);
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL b2b_lo got=%h required a5a50f0f", v); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_hi got=%h required 0badf00d", v); end
    endtask

    task automatic test_accumulate();
        logic [31:0] v;
        issue(OP_MTLO, 32'd5, 32'd0);
        issue(OP_MTHI, 32'd0, 32'd0);
`ifdef MULDIV_EXEC_MADD_EN
        issue(OP_MADD, 32'd3, 32'd4);
        wait_idle();
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'd17) begin n_fail++; $display("FAIL madd_lo got=%h required 00000011", v); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL madd_hi got=%h required 00000000", v); end
        issue(OP_MSUBU, 32'd1, 32'd18);
        wait_idle();
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL msubu_lo got=%h required ffffffff", v); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL msubu_hi got=%h required ffffffff", v); end
`else
        begin
            int bcnt = 0;
            issue(OP_MADD, 32'd3, 32'd4);
            issue(4'd15, 32'd9, 32'd9);
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (busy) bcnt++;
            end
            n_cmp++;
            if (bcnt != 0) begin n_fail++; $display("FAIL noop_busy_cycles got=%0d required 0", bcnt); end
        end
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'd5) begin n_fail++; $display("FAIL noop_lo got=%h required 00000005", v); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL noop_hi got=%h required 00000000", v); end
`endif
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] v;
        issue(OP_MTLO, 32'h0000_CAFE, 32'd0);
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'h0000_CAFE) begin n_fail++; $display("FAIL pre_reset_lo got=%h required 0000cafe", v); end
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_div_busy got=%b required 1", busy); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({result, out_valid, busy, div_by_zero} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset result=%h ov=%b busy=%b dbz=%b required 0/0/0/0",
                     result, out_valid, busy, div_by_zero);
        end
        @(negedge clock);
        reset_n = 1'b1;
        read_reg(OP_MFLO, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL post_reset_lo got=%h required 00000000", v); end
        read_reg(OP_MFHI, v);
        n_cmp++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL post_reset_hi got=%h required 00000000", v); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_mt_mf_backpressure();
        test_accumulate();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_exec_unit.md
Name: muldiv_exec_unit

Overview:
- Parametrised multi-cycle multiply/divide execution unit with architectural HI/LO registers; the next generation of the single-cycle execute stage.
- Sits beside the single-cycle ALU in the execute stage. The ALU forwards MULT/DIV/MFHI/MFLO/MTHI/MTLO here via a valid/ready handshake; results return on a second valid/ready channel.
- Iterative radix-2 shift-add multiplier and restoring divider, with configurable data width and bits processed per cycle.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even and >= 8.
- STEPS_PER_CYCLE, 1, iteration steps per clock; legal values are 1, 2 and 4; must divide WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  4  operation code (see Behaviour).
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- src_b  input  WIDTH  rt operand (divisor / multiplier).
- out_valid  output  1  result valid (MFHI/MFLO only).
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  read-back value.
- busy  output  1  high while an iterative operation is in flight.
- div_by_zero  output  1  one-cycle pulse when DIV/DIVU completes with src_b == 0.

Behaviour:
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, 8-11 MADD/MADDU/MSUB/MSUBU (optional). All other codes are accepted as no-ops.
- Transfers: a request transfers on in_valid && in_ready; a result transfers on out_valid && out_ready.
- in_ready = (state == IDLE) && !(out_valid && !out_ready).
- Reset (async, reset_n low): state IDLE; HI = LO = 0; result = 0; out_valid = busy = div_by_zero = 0; all iteration counters and datapath registers cleared. Reset asserted mid-operation aborts it; HI/LO read 0 afterwards.
- FSM states: IDLE, MUL, DIV, FIXUP.
- IDLE -> MUL on accepted MULT/MULTU (and MADD* when enabled).
- IDLE -> DIV on accepted DIV/DIVU with src_b != 0.
- MUL/DIV -> FIXUP after WIDTH/STEPS_PER_CYCLE iteration cycles.
- FIXUP -> IDLE after one cycle.
- Signed ops: operands are converted to magnitudes on accept; the sign is applied in FIXUP.
- Multiply: full 2*WIDTH product; HI = upper half, LO = lower half.
- Divide: LO = quotient, HI = remainder. Quotient truncates toward zero; the remainder takes the dividend's sign.
- Signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0. No flag is raised.
- Divide by zero: no iteration. The accept cycle writes LO = all ones and HI = src_a, and div_by_zero pulses the following cycle. State stays IDLE.
- HI/LO update on the FIXUP clock edge, so total latency is 1 + WIDTH/STEPS_PER_CYCLE + 1 cycles from accept to HI/LO visible (34 cycles for the defaults).
- busy is high from the cycle after accept through FIXUP inclusive.
- MTHI/MTLO: HI/LO written with src_a on the accept edge; no output.
- MFHI/MFLO: result registered on the accept edge; out_valid rises the next cycle. result and out_valid are held stable until out_ready; out_valid clears on transfer.
- MF* issued while busy is stalled by in_ready low, never served stale. An MF* accepted in the same cycle as a completing FIXUP is impossible because in_ready is low in FIXUP.

Optional Feature:
- Macro: MULDIV_EXEC_MADD_EN.
- Defined: ops 8-11 multiply as MULT/MULTU, then in FIXUP add (MADD*) or subtract (MSUB*) the product to/from {HI,LO} modulo 2^(2*WIDTH). Latency is the same as MULT.
- Undefined: ops 8-11 are accepted as no-ops, HI/LO are unchanged, and the accumulate adder is not synthesised.

Decomposition:
- Package muldiv_pkg: op-code localparams, FSM state encoding, and the STEPS_PER_CYCLE legality check.
- One sub-module, muldiv_iter_core: a shared 2*WIDTH shift register with an add/subtract step that performs STEPS_PER_CYCLE multiply or restoring-divide steps per cycle under start/mode control.
- The top level owns the handshake, FSM, sign fix-up and HI/LO.

Test Plan:
- MULT src_a=-3, src_b=7 (WIDTH 32), then MFHI/MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for exactly 33 cycles.
- DIV 7 / -2 -> LO=0xFFFFFFFD, HI=0x00000001. DIVU 0xFFFFFFFF / 0x10 -> LO=0x0FFFFFFF, HI=0x0000000F.
- DIVU 0x80000000 / 0 -> div_by_zero single pulse, LO=0xFFFFFFFF, HI=0x80000000, busy never high. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678, MFHI with out_ready low for 3 cycles -> result=0x12345678 and out_valid held, in_ready low; transfer on cycle 4, then in_ready high.
- Reset asserted at iteration 10 of DIV -> all outputs 0 asynchronously; after release MFLO returns 0.
- With MULDIV_EXEC_MADD_EN: MTLO 5, MTHI 0, MADD 3*4 -> LO=17, HI=0. MSUBU 1*18 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF.
